// File: rtl/rename_free_list.sv
// rename_free_list -- physical-register free list for the rename stage.
//
// Keeps a bitmap of unallocated physical registers plus three staged slots
// (A, B, C) whose tags can be granted in the same cycle they are requested.
// Tags returned by commit / branch-miss recovery are merged into the bitmap
// and become pickable on the following cycle.
//
// Optional feature: define RENAME_FREE_LIST_DFREE_CHECK_EN to build the
// sticky double-free detector driving err_dfree; otherwise err_dfree is 0.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   alloc_cnt  number of tags requested this cycle (0..3)
//   alloc_rdy  all three slots valid (grants possible)
//   alloc_v    grant mask, bit i set when alloc_rdy and i < alloc_cnt
//   rgta/b/c   granted tags of slots A/B/C, 0 when not granted
//   free_v     per-port return valid
//   free_tag   per-port returned tag, port i at [7*i +: 7]
//   free_cnt   registered count of free registers (bitmap + valid slots)
//   err_dfree  sticky double-free error
module rename_free_list #(
  parameter int unsigned NPREG = 96,
  parameter int unsigned NAREG = 32,
  parameter int unsigned NFREE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           alloc_cnt,
  output logic                 alloc_rdy,
  output logic [2:0]           alloc_v,
  output logic [6:0]           rgta,
  output logic [6:0]           rgtb,
  output logic [6:0]           rgtc,
  input  logic [NFREE-1:0]     free_v,
  input  logic [7*NFREE-1:0]   free_tag,
  output logic [6:0]           free_cnt,
  output logic                 err_dfree
);

  localparam int unsigned TW = 7;
  localparam logic [NPREG-1:0] RST_MAP = {{(NPREG-NAREG){1'b1}}, {NAREG{1'b0}}};

  logic [NPREG-1:0] fmap, fmap_n;
  logic [2:0]       slot_v, slot_v_n, needy;
  logic [TW-1:0]    slot_tag   [3];
  logic [TW-1:0]    slot_tag_n [3];
  logic [TW-1:0]    pick_tag   [4];
  logic             pick_ok    [4];
  logic [TW-1:0]    ret_tag    [NFREE];
  logic [NFREE-1:0] ret_ok;
  logic [1:0]       rank;
  logic [6:0]       cnt_n;

  // Grant: all-or-nothing, slots consumed in order A, B, C.
  always_comb begin
    alloc_rdy  = &slot_v;
    alloc_v[0] = alloc_rdy && (alloc_cnt != 2'd0);
    alloc_v[1] = alloc_rdy && (alloc_cnt >= 2'd2);
    alloc_v[2] = alloc_rdy && (alloc_cnt == 2'd3);
    rgta = alloc_v[0] ? slot_tag[0] : '0;
    rgtb = alloc_v[1] ? slot_tag[1] : '0;
    rgtc = alloc_v[2] ? slot_tag[2] : '0;
    needy = ~slot_v | alloc_v;
  end

  // Picks from the current bitmap: lowest, highest (distinct from lowest),
  // and lowest excluding both previous picks. Entry 3 is a never-valid pad.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      pick_tag[k] = '0;
      pick_ok[k]  = 1'b0;
    end
    for (int unsigned i = 0; i < NPREG; i++) begin
      if (fmap[i] && !pick_ok[0]) begin
        pick_tag[0] = TW'(i);
        pick_ok[0]  = 1'b1;
      end
      if (fmap[i]) pick_tag[1] = TW'(i);
    end
    pick_ok[1] = pick_ok[0] && (pick_tag[1] != pick_tag[0]);
    if (!pick_ok[1]) pick_tag[1] = '0;
    for (int unsigned i = 0; i < NPREG; i++) begin
      if (fmap[i] && !pick_ok[2] && TW'(i) != pick_tag[0] && TW'(i) != pick_tag[1]) begin
        pick_tag[2] = TW'(i);
        pick_ok[2]  = 1'b1;
      end
    end
  end

  // Return ports: tag 0 and out-of-range tags are dropped.
  always_comb begin
    for (int unsigned p = 0; p < NFREE; p++) begin
      ret_tag[p] = free_tag[p*TW +: TW];
      ret_ok[p]  = free_v[p] && (ret_tag[p] != '0) && (32'(ret_tag[p]) < NPREG);
    end
  end

  // Refill: the n-th needy slot (in A, B, C order) takes the n-th pick.
  // Returns are applied after pick clears, so they only become pickable
  // from the next cycle's bitmap.
  always_comb begin
    fmap_n   = fmap;
    slot_v_n = slot_v;
    rank     = '0;
    for (int unsigned s = 0; s < 3; s++) slot_tag_n[s] = slot_tag[s];
    for (int unsigned s = 0; s < 3; s++) begin
      if (needy[s]) begin
        slot_v_n[s]   = pick_ok[rank];
        slot_tag_n[s] = pick_ok[rank] ? pick_tag[rank] : '0;
        if (pick_ok[rank]) fmap_n[pick_tag[rank]] = 1'b0;
        rank = rank + 2'd1;
      end
    end
    for (int unsigned p = 0; p < NFREE; p++) begin
      if (ret_ok[p]) fmap_n[ret_tag[p]] = 1'b1;
    end
    cnt_n = '0;
    for (int unsigned i = 0; i < NPREG; i++) cnt_n = cnt_n + 7'(fmap_n[i]);
    for (int unsigned s = 0; s < 3; s++) cnt_n = cnt_n + 7'(slot_v_n[s]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fmap     <= RST_MAP;
      slot_v   <= '0;
      free_cnt <= 7'(NPREG - NAREG);
      for (int unsigned s = 0; s < 3; s++) slot_tag[s] <= '0;
    end else begin
      fmap     <= fmap_n;
      slot_v   <= slot_v_n;
      free_cnt <= cnt_n;
      for (int unsigned s = 0; s < 3; s++) slot_tag[s] <= slot_tag_n[s];
    end
  end

`ifdef RENAME_FREE_LIST_DFREE_CHECK_EN
  logic dfree_hit;

  // A return is a double free if the tag is already free in the bitmap or
  // still staged in a slot that is not being granted this cycle.
  always_comb begin
    dfree_hit = 1'b0;
    for (int unsigned p = 0; p < NFREE; p++) begin
      if (ret_ok[p]) begin
        if (fmap[ret_tag[p]]) dfree_hit = 1'b1;
        for (int unsigned s = 0; s < 3; s++) begin
          if (slot_v[s] && !alloc_v[s] && slot_tag[s] == ret_tag[p]) dfree_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_dfree <= 1'b0;
    else if (dfree_hit) err_dfree <= 1'b1;
  end
`else
  assign err_dfree = 1'b0;
`endif

endmodule

// File: tb/tb_rename_free_list.sv
module tb_rename_free_list;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  alloc_cnt;
  logic        alloc_rdy;
  logic [2:0]  alloc_v;
  logic [6:0]  rgta, rgtb, rgtc;
  logic [3:0]  free_v;
  logic [27:0] free_tag;
  logic [6:0]  free_cnt;
  logic        err_dfree;

  int errors = 0;
  int checks = 0;

`ifdef RENAME_FREE_LIST_DFREE_CHECK_EN
  localparam logic EXP_DF = 1'b1;
`else
  localparam logic EXP_DF = 1'b0;
`endif

  rename_free_list #(.NPREG(96), .NAREG(32), .NFREE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .alloc_cnt (alloc_cnt),
    .alloc_rdy (alloc_rdy),
    .alloc_v   (alloc_v),
    .rgta      (rgta),
    .rgtb      (rgtb),
    .rgtc      (rgtc),
    .free_v    (free_v),
    .free_tag  (free_tag),
    .free_cnt  (free_cnt),
    .err_dfree (err_dfree)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ret(input int port, input logic [6:0] tag);
    free_v[port] = 1'b1;
    free_tag[port*7 +: 7] = tag;
  endtask

  task automatic clr_ret();
    free_v   = '0;
    free_tag = '0;
  endtask

  // Look at the staged tags without consuming them: request 3, sample, withdraw.
  task automatic peek(input string tag, input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
    alloc_cnt = 2'd3;
    #1;
    chk({tag, "_a"}, 32'(rgta), 32'(a));
    chk({tag, "_b"}, 32'(rgtb), 32'(b));
    chk({tag, "_c"}, 32'(rgtc), 32'(c));
    alloc_cnt = 2'd0;
    #1;
  endtask

  initial begin
    rst = 1'b1; alloc_cnt = 2'd3; clr_ret();
    tick(); tick();
    chk("rst_rdy", 32'(alloc_rdy), 0);
    chk("rst_av", 32'(alloc_v), 0);
    chk("rst_rgta", 32'(rgta), 0);
    chk("rst_cnt", 32'(free_cnt), 64);
    chk("rst_err", 32'(err_dfree), 0);

    // first edge after release stages 32 / 95 / 33
    rst = 1'b0; alloc_cnt = 2'd0;
    tick();
    chk("load_rdy", 32'(alloc_rdy), 1);
    chk("load_cnt", 32'(free_cnt), 64);
    chk("load_av", 32'(alloc_v), 0);
    chk("load_rgta", 32'(rgta), 0);

    // 3-wide grant
    alloc_cnt = 2'd3; #1;
    chk("g3_av", 32'(alloc_v), 7);
    chk("g3_a", 32'(rgta), 32);
    chk("g3_b", 32'(rgtb), 95);
    chk("g3_c", 32'(rgtc), 33);
    tick(); alloc_cnt = 2'd0; #1;
    chk("g3_cnt", 32'(free_cnt), 61);
    peek("g3_next", 7'd34, 7'd94, 7'd35);

    // 1-wide grant from a fresh state
    rst = 1'b1; tick(); rst = 1'b0; tick();
    alloc_cnt = 2'd1; #1;
    chk("g1_av", 32'(alloc_v), 1);
    chk("g1_a", 32'(rgta), 32);
    chk("g1_b", 32'(rgtb), 0);
    chk("g1_c", 32'(rgtc), 0);
    tick(); alloc_cnt = 2'd0; #1;
    chk("g1_cnt", 32'(free_cnt), 63);
    peek("g1_next", 7'd34, 7'd95, 7'd33);

    // drain the remaining 63 tags with 21 three-wide grants
    for (int k = 0; k < 21; k++) begin
      alloc_cnt = 2'd3; #1;
      chk("drain_rdy", 32'(alloc_rdy), 1);
      tick(); alloc_cnt = 2'd0; #1;
      chk("drain_cnt", 32'(free_cnt), 32'(63 - 3*(k+1)));
    end
    chk("empty_rdy", 32'(alloc_rdy), 0);
    alloc_cnt = 2'd3; #1;
    chk("empty_av", 32'(alloc_v), 0);
    chk("empty_rgta", 32'(rgta), 0);
    alloc_cnt = 2'd0;

    // return 40: bitmap at edge N, slot A at edge N+1
    ret(0, 7'd40);
    tick(); clr_ret(); #1;
    chk("r40_n_cnt", 32'(free_cnt), 1);
    chk("r40_n_rdy", 32'(alloc_rdy), 0);
    tick();
    chk("r40_n1_cnt", 32'(free_cnt), 1);
    chk("r40_n1_rdy", 32'(alloc_rdy), 0);
    ret(1, 7'd50); ret(3, 7'd60);
    tick(); clr_ret(); #1;
    chk("r5060_cnt", 32'(free_cnt), 3);
    chk("r5060_rdy", 32'(alloc_rdy), 0);
    tick();
    chk("refill_rdy", 32'(alloc_rdy), 1);
    chk("refill_cnt", 32'(free_cnt), 3);
    peek("refill", 7'd40, 7'd50, 7'd60);

    // tag 0 ignored, tag 5 accepted
    ret(0, 7'd0); ret(2, 7'd5);
    tick(); clr_ret(); #1;
    chk("r0_5_cnt", 32'(free_cnt), 4);

    // grant and return in the same cycle
    alloc_cnt = 2'd1; ret(1, 7'd70); #1;
    chk("gr_av", 32'(alloc_v), 1);
    chk("gr_a", 32'(rgta), 40);
    tick(); clr_ret(); alloc_cnt = 2'd0; #1;
    chk("gr_cnt", 32'(free_cnt), 4);
    peek("gr_next", 7'd5, 7'd50, 7'd60);

    // duplicate tag on two ports, out-of-range tag ignored
    ret(0, 7'd80); ret(1, 7'd80); ret(3, 7'd100);
    tick(); clr_ret(); #1;
    chk("dup_cnt", 32'(free_cnt), 5);
    chk("legal_err", 32'(err_dfree), 0);

    // double free of a staged tag (95 in slot B)
    rst = 1'b1; tick(); rst = 1'b0; tick();
    ret(0, 7'd95);
    tick(); clr_ret(); #1;
    chk("df_err", 32'(err_dfree), 32'(EXP_DF));
    tick();
    chk("df_sticky", 32'(err_dfree), 32'(EXP_DF));
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("df_rst", 32'(err_dfree), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
